// File: rtl/conv_window_ctrl.sv
// 3x3 window sequencer for the conv MAC datapath: fetches each window, fires the datapath, writes the result.
// Optional CONV_STRIDE2_EN selects stride 2 (dense output indexing); default build is stride 1.
//
// state | meaning
// IDLE  | waiting for start_i
// LOAD  | 9 reads of the current window, returning bytes latched into win_o one cycle later
// CAPT  | last window byte latched, window now stable
// FIRE  | conv_fire_o pulse, datapath samples win_o
// WRITE | result presented, held until wr_ready_i
// DONE  | one-cycle done_o pulse
module conv_window_ctrl #(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int ADDR_W  = 6,
    parameter int OADDR_W = 6,
    parameter int RES_W   = 64
) (
    input  logic                clk_i,
    input  logic                rst_n,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                rd_en_o,
    output logic [ADDR_W-1:0]   rd_addr_o,
    input  logic signed [7:0]   rd_data_i,
    output logic [71:0]         win_o,
    output logic                conv_fire_o,
    input  logic [RES_W-1:0]    res_i,
    output logic                wr_en_o,
    output logic [OADDR_W-1:0]  wr_addr_o,
    output logic [RES_W-1:0]    wr_data_o,
    input  logic                wr_ready_i
);

`ifdef CONV_STRIDE2_EN
    localparam int STRIDE = 2;
`else
    localparam int STRIDE = 1;
`endif
    localparam int OUT_W    = (IMG_W - 3) / STRIDE + 1;
    localparam int OUT_H    = (IMG_H - 3) / STRIDE + 1;
    localparam int LAST_COL = (OUT_W - 1) * STRIDE;
    localparam int LAST_ROW = (OUT_H - 1) * STRIDE;
    localparam int CW       = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H) + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CAPT  = 3'd2,
        FIRE  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t               state;
    logic [CW-1:0]        row;
    logic [CW-1:0]        col;
    logic [OADDR_W-1:0]   oidx;
    logic [3:0]           k;
    logic [1:0]           kr;
    logic [1:0]           kc;

    logic [1:0]           next_kr;
    logic [1:0]           next_kc;
    logic                 last_col;
    logic                 last_pos;
    logic [CW-1:0]        next_col;
    logic [CW-1:0]        next_row;

    function automatic logic [ADDR_W-1:0] win_addr(input logic [CW-1:0] r, input logic [CW-1:0] c,
                                                    input logic [1:0] dr, input logic [1:0] dc);
        return ADDR_W'((int'(r) + int'(dr)) * IMG_W + int'(c) + int'(dc));
    endfunction

    always_comb begin
        next_kc  = (kc == 2'd2) ? 2'd0 : kc + 2'd1;
        next_kr  = (kc == 2'd2) ? kr + 2'd1 : kr;
        last_col = (col == CW'(LAST_COL));
        last_pos = last_col && (row == CW'(LAST_ROW));
        next_col = last_col ? '0 : col + CW'(STRIDE);
        next_row = last_col ? row + CW'(STRIDE) : row;
    end

    assign wr_data_o = wr_en_o ? res_i : '0;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            rd_en_o     <= 1'b0;
            rd_addr_o   <= '0;
            win_o       <= '0;
            conv_fire_o <= 1'b0;
            wr_en_o     <= 1'b0;
            wr_addr_o   <= '0;
            row         <= '0;
            col         <= '0;
            oidx        <= '0;
            k           <= '0;
            kr          <= '0;
            kc          <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        state     <= LOAD;
                        busy_o    <= 1'b1;
                        row       <= '0;
                        col       <= '0;
                        oidx      <= '0;
                        k         <= '0;
                        kr        <= '0;
                        kc        <= '0;
                        rd_en_o   <= 1'b1;
                        rd_addr_o <= '0;
                    end
                end
                LOAD: begin
                    // byte returning now belongs to the read issued last cycle
                    if (k != 4'd0)
                        win_o[{k - 4'd1, 3'b000} +: 8] <= rd_data_i;
                    if (k == 4'd8) begin
                        state     <= CAPT;
                        rd_en_o   <= 1'b0;
                        rd_addr_o <= '0;
                    end else begin
                        k         <= k + 4'd1;
                        kr        <= next_kr;
                        kc        <= next_kc;
                        rd_addr_o <= win_addr(row, col, next_kr, next_kc);
                    end
                end
                CAPT: begin
                    win_o[71:64] <= rd_data_i;
                    conv_fire_o  <= 1'b1;
                    state        <= FIRE;
                end
                FIRE: begin
                    conv_fire_o <= 1'b0;
                    wr_en_o     <= 1'b1;
                    wr_addr_o   <= oidx;
                    state       <= WRITE;
                end
                WRITE: begin
                    if (wr_ready_i) begin
                        wr_en_o <= 1'b0;
                        oidx    <= oidx + OADDR_W'(1);
                        if (last_pos) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state     <= LOAD;
                            col       <= next_col;
                            row       <= next_row;
                            k         <= '0;
                            kr        <= '0;
                            kc        <= '0;
                            rd_en_o   <= 1'b1;
                            rd_addr_o <= win_addr(next_row, next_col, 2'd0, 2'd0);
                        end
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Randomized bench for conv_window_ctrl: reads, windows and writes are checked against a per-frame
// model built directly from the image, stride and output-grid rules.
module tb_conv_window_ctrl;

`ifdef CONV_STRIDE2_EN
    localparam int W = 5, H = 5, S = 2;
`else
    localparam int W = 4, H = 4, S = 1;
`endif
    localparam int OW = (W - 3) / S + 1;
    localparam int OH = (H - 3) / S + 1;
    localparam int NOUT = OW * OH;
    localparam int ADDR_W = 6, OADDR_W = 6, RES_W = 64;

    logic               clk_i = 1'b0;
    logic               rst_n;
    logic               start_i;
    logic               busy_o, done_o, rd_en_o, conv_fire_o, wr_en_o, wr_ready_i;
    logic [ADDR_W-1:0]  rd_addr_o;
    logic [7:0]         rd_data_i;
    logic [71:0]        win_o;
    logic [RES_W-1:0]   res_i;
    logic [OADDR_W-1:0] wr_addr_o;
    logic [RES_W-1:0]   wr_data_o;

    conv_window_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(ADDR_W), .OADDR_W(OADDR_W), .RES_W(RES_W)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i), .win_o(win_o),
        .conv_fire_o(conv_fire_o), .res_i(res_i), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
        .wr_data_o(wr_data_o), .wr_ready_i(wr_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          idx;
        logic [71:0] win;
        logic [63:0] res;
    } wr_t;

    logic [7:0]  mem [0:63];
    int          exp_rd[$];
    wr_t         exp_wr[$];
    int          n_vec = 0, n_err = 0;
    int          cyc = 0;
    int          n_rd = 0, n_wr = 0, n_fire = 0, n_done = 0;
    int          rmode = 0, stall_left = 0;
    bit          stall_prev = 0;
    logic [63:0] prev_data;
    logic [71:0] prev_win;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stand-in datapath: any fixed function of the window, signed int8 pixels, ReLU applied.
    function automatic logic [63:0] conv_ref(input logic [71:0] w);
        longint acc = 0;
        for (int i = 0; i < 9; i++)
            acc += longint'($signed(w[i*8 +: 8])) * longint'(i * 7 - 20);
        if (acc < 0) acc = 0;
        return {32'(acc) ^ 32'hC0DE_0000, 32'(acc * 3 + 1)};
    endfunction

    always @(posedge clk_i) if (rd_en_o) rd_data_i <= mem[rd_addr_o];
    always @(posedge clk_i) if (conv_fire_o) res_i <= conv_ref(win_o);

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    initial forever begin
        @(posedge clk_i);
        #2;
        case (rmode)
            1: wr_ready_i = ($urandom_range(0, 3) != 0);
            2: if (wr_en_o && stall_left > 0) begin
                   wr_ready_i = 1'b0;
                   stall_left--;
               end else wr_ready_i = 1'b1;
            default: wr_ready_i = 1'b1;
        endcase
    end

    task automatic build_model();
        exp_rd.delete();
        exp_wr.delete();
        for (int orow = 0; orow < OH; orow++)
            for (int ocol = 0; ocol < OW; ocol++) begin
                wr_t e;
                e.win = '0;
                for (int kr = 0; kr < 3; kr++)
                    for (int kc = 0; kc < 3; kc++) begin
                        int a;
                        a = (orow * S + kr) * W + ocol * S + kc;
                        exp_rd.push_back(a);
                        e.win[(kr * 3 + kc) * 8 +: 8] = mem[a];
                    end
                e.idx = orow * OW + ocol;
                e.res = conv_ref(e.win);
                exp_wr.push_back(e);
            end
    endtask

    initial forever begin
        @(negedge clk_i);
        if (rst_n) begin
            if (rd_en_o) begin
                n_rd++;
                if (exp_rd.size() == 0) chk("rd_extra", 72'(rd_addr_o), 72'(0));
                else chk("rd_addr", 72'(rd_addr_o), 72'(exp_rd.pop_front()));
            end
            if (stall_prev) begin
                chk("stall_wr_en", 72'(wr_en_o), 72'(1));
                chk("stall_data", 72'(wr_data_o), 72'(prev_data));
                chk("stall_win", win_o, prev_win);
            end
            stall_prev = wr_en_o && !wr_ready_i;
            prev_data  = wr_data_o;
            prev_win   = win_o;
            if (wr_en_o && wr_ready_i) begin
                n_wr++;
                if (exp_wr.size() == 0) chk("wr_extra", 72'(wr_addr_o), 72'(0));
                else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", 72'(wr_addr_o), 72'(e.idx));
                    chk("wr_data", 72'(wr_data_o), 72'(e.res));
                    chk("win", win_o, e.win);
                end
            end
            if (conv_fire_o) n_fire++;
            if (done_o) n_done++;
        end
    end

    task automatic run_frame(input int ready_mode, input bit mid_start, input bit check_len);
        int t0, td, busy_low;
        bit got;
        build_model();
        n_wr = 0; n_fire = 0; n_done = 0; n_rd = 0;
        busy_low = 0; got = 0; td = 0;
        @(posedge clk_i); #2;
        rmode = ready_mode;
        stall_left = 5;
        start_i = 1'b1;
        t0 = cyc;
        @(posedge clk_i); #2;
        start_i = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                got = 1;
                td = cyc;
            end else if (!busy_o) busy_low++;
            if (mid_start) start_i = (i == 20);
        end
        start_i = 1'b0;
        chk("done_seen", 72'(got), 72'(1));
        if (check_len)
            chk("frame_len", 72'(td - t0 + 1), 72'(12 * NOUT + 2 + (ready_mode == 2 ? 5 : 0)));
        chk("busy_in_frame", 72'(busy_low), 72'(0));
        @(negedge clk_i);
        chk("done_pulse", 72'(done_o), 72'(0));
        chk("busy_after", 72'(busy_o), 72'(0));
        chk("n_writes", 72'(n_wr), 72'(NOUT));
        chk("n_fire", 72'(n_fire), 72'(NOUT));
        chk("n_done", 72'(n_done), 72'(1));
        chk("rd_left", 72'(exp_rd.size()), 72'(0));
        chk("wr_left", 72'(exp_wr.size()), 72'(0));
        rmode = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 72'(busy_o), 72'(0));
        chk({tag, "_done"}, 72'(done_o), 72'(0));
        chk({tag, "_rd_en"}, 72'(rd_en_o), 72'(0));
        chk({tag, "_rd_addr"}, 72'(rd_addr_o), 72'(0));
        chk({tag, "_win"}, win_o, 72'(0));
        chk({tag, "_fire"}, 72'(conv_fire_o), 72'(0));
        chk({tag, "_wr_en"}, 72'(wr_en_o), 72'(0));
        chk({tag, "_wr_addr"}, 72'(wr_addr_o), 72'(0));
        chk({tag, "_wr_data"}, 72'(wr_data_o), 72'(0));
    endtask

    task automatic reset_mid_frame();
        bit reached;
        reached = 0;
        build_model();
        n_rd = 0; n_done = 0;
        @(posedge clk_i); #2;
        start_i = 1'b1;
        @(posedge clk_i); #2;
        start_i = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(negedge clk_i);
            if (n_rd >= 11) reached = 1;
        end
        chk("reach_2nd_load", 72'(reached), 72'(1));
        #1 rst_n = 1'b0;
        #1 check_all_zero("abort");
        exp_rd.delete();
        exp_wr.delete();
        stall_prev = 0;
        @(negedge clk_i);
        chk("abort_no_done", 72'(n_done), 72'(0));
        @(negedge clk_i);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start_i = 1'b0;
        wr_ready_i = 1'b1;
        res_i = '0;
        for (int a = 0; a < 64; a++) mem[a] = 8'(a);
        #12 check_all_zero("reset");
        @(negedge clk_i);
        #1 rst_n = 1'b1;

        run_frame(0, 0, 1);
        run_frame(2, 0, 1);
        run_frame(0, 1, 1);
        reset_mid_frame();
        run_frame(0, 0, 1);

        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < 64; a++) mem[a] = 8'($urandom);
            run_frame(1, it[0], 0);
        end
        run_frame(0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected frames to complete");
        $fatal(1);
    end

endmodule
